// File: rtl/persp_divide.sv
// Perspective divide: clip-space vertex to NDC via a 33-cycle restoring 1/w divide and three serial multiplies.
// Define PERSP_VIEWPORT_EN to add the viewport transform stage (VP) before the result is presented.
module persp_divide (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_vec,
  input  logic [31:0]  vp_x,
  input  logic [31:0]  vp_y,
  input  logic [31:0]  vp_half_w,
  input  logic [31:0]  vp_half_h,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_vec,
  output logic         out_w_zero,
  output logic         out_behind
);

  localparam logic [31:0] Q_ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIV  = 3'd1,
    MUL  = 3'd2,
`ifdef PERSP_VIEWPORT_EN
    VP   = 3'd3,
`endif
    OUT  = 3'd4
  } state_t;

  state_t           state_reg;
  logic [31:0]      x_reg, y_reg, z_reg;
  logic [31:0]      divisor_reg;
  logic [32:0]      rem_reg;
  logic [31:0]      quo_reg;
  logic [5:0]       div_cnt_reg;
  logic [31:0]      recip_reg;
  logic [1:0]       mul_idx_reg;
  logic [1:0][31:0] ndc_reg;

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647)
      sat32 = 32'h7FFF_FFFF;
    else if (v < -64'sd2147483648)
      sat32 = 32'h8000_0000;
    else
      sat32 = v[31:0];
  endfunction

  function automatic logic [31:0] add_sat(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if ((a[31] == b[31]) && (s[31] != a[31]))
      add_sat = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      add_sat = s;
  endfunction

  function automatic logic [31:0] mul_q16(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mul_q16 = sat32(p >>> 16);
  endfunction

  assign in_ready = (state_reg == IDLE);

  // Restoring divide of 2^32: the only set dividend bit is the first one shifted in.
  logic [33:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [32:0] quo_next;

  always_comb begin
    div_shift = {rem_reg, (div_cnt_reg == 6'd0)};
    div_ge    = (div_shift >= {2'b00, divisor_reg});
    div_diff  = div_shift[32:0] - {1'b0, divisor_reg};
    quo_next  = {quo_reg, div_ge};
  end

  // Shared multiplier for x, y, z; recip is never negative so it is zero-extended.
  logic [31:0]        mul_a;
  logic signed [63:0] mul_p;
  logic signed [63:0] mul_s;
  logic [31:0]        mul_res;

  always_comb begin
    case (mul_idx_reg)
      2'd0:    mul_a = x_reg;
      2'd1:    mul_a = y_reg;
      default: mul_a = z_reg;
    endcase
    mul_p = $signed({{32{mul_a[31]}}, mul_a}) * $signed({32'd0, recip_reg});
    mul_s = mul_p >>> 16;
    if (out_behind)
      mul_s = -mul_s;
    mul_res = sat32(mul_s);
  end

`ifdef PERSP_VIEWPORT_EN
  logic [1:0][31:0] vp_org_reg;
  logic [1:0][31:0] vp_half_reg;
  logic [1:0][31:0] vp_scr;
  logic [31:0]      ndc_z_reg;
  logic [31:0]      vp_zsum;
  logic [31:0]      vp_zs;

  // Lane 0 is x, lane 1 is y.
  for (genvar gi = 0; gi < 2; gi++) begin : g_vp_lane
    assign vp_scr[gi] = add_sat(vp_org_reg[gi], mul_q16(ndc_reg[gi], vp_half_reg[gi]));
  end

  assign vp_zsum = add_sat(ndc_z_reg, Q_ONE);
  assign vp_zs   = {vp_zsum[31], vp_zsum[31:1]};
`else
  logic unused_vp;
  assign unused_vp = ^{vp_x, vp_y, vp_half_w, vp_half_h};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_cnt_reg <= '0;
      recip_reg   <= '0;
      mul_idx_reg <= '0;
      ndc_reg     <= '0;
      out_valid   <= 1'b0;
      out_vec     <= '0;
      out_w_zero  <= 1'b0;
      out_behind  <= 1'b0;
`ifdef PERSP_VIEWPORT_EN
      vp_org_reg  <= '0;
      vp_half_reg <= '0;
      ndc_z_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg       <= in_vec[127:96];
            y_reg       <= in_vec[95:64];
            z_reg       <= in_vec[63:32];
            // Two's complement magnitude; 0x8000_0000 maps to 2^31 as an unsigned value.
            divisor_reg <= in_vec[31] ? (~in_vec[31:0] + 32'd1) : in_vec[31:0];
            out_w_zero  <= (in_vec[31:0] == 32'd0);
            out_behind  <= in_vec[31];
            rem_reg     <= '0;
            quo_reg     <= '0;
            div_cnt_reg <= '0;
`ifdef PERSP_VIEWPORT_EN
            vp_org_reg  <= {vp_y, vp_x};
            vp_half_reg <= {vp_half_h, vp_half_w};
`endif
            state_reg   <= DIV;
          end
        end

        DIV: begin
          rem_reg     <= div_ge ? div_diff : div_shift[32:0];
          quo_reg     <= quo_next[31:0];
          div_cnt_reg <= div_cnt_reg + 6'd1;
          if (div_cnt_reg == 6'd32) begin
            if (out_w_zero || (quo_next[32:31] != 2'b00))
              recip_reg <= 32'h7FFF_FFFF;
            else
              recip_reg <= quo_next[31:0];
            mul_idx_reg <= 2'd0;
            state_reg   <= MUL;
          end
        end

        MUL: begin
          mul_idx_reg <= mul_idx_reg + 2'd1;
          case (mul_idx_reg)
            2'd0: ndc_reg[0] <= mul_res;
            2'd1: ndc_reg[1] <= mul_res;
            default: begin
`ifdef PERSP_VIEWPORT_EN
              ndc_z_reg <= mul_res;
              state_reg <= VP;
`else
              out_vec   <= {ndc_reg[0], ndc_reg[1], mul_res, Q_ONE};
              out_valid <= 1'b1;
              state_reg <= OUT;
`endif
            end
          endcase
        end

`ifdef PERSP_VIEWPORT_EN
        VP: begin
          out_vec   <= {vp_scr[0], vp_scr[1], vp_zs, Q_ONE};
          out_valid <= 1'b1;
          state_reg <= OUT;
        end
`endif

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
